// File: rtl/enigma_pkg.sv
// Shared constants and types for the enigma two-port QoS arbiter slice.
package enigma_pkg;

    localparam int DEF_PLD_W      = 128;
    localparam int DEF_ID_W       = 5;
    localparam int DEF_QOS_W      = 2;
    localparam int DEF_STARVE_LIM = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/enigma_arb_if.sv
// Valid/ready request channel carrying payload, ID and QoS.
interface enigma_arb_if #(
    parameter int PLD_W = 128,
    parameter int ID_W  = 5,
    parameter int QOS_W = 2
);
    logic [PLD_W-1:0] payload;
    logic [ID_W-1:0]  id;
    logic [QOS_W-1:0] qos;
    logic             valid;
    logic             ready;

    modport master (output payload, output id, output qos, output valid, input ready);
    modport slave  (input payload, input id, input qos, input valid, output ready);
endinterface

// File: rtl/enigma_id_sb.sv
// Busy-ID scoreboard: one bit per merged ID, two lookups and an incremental busy count.
module enigma_id_sb #(
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [ID_W:0]   set_id,
    input  logic            clr_en,
    input  logic [ID_W:0]   clr_id,
    input  logic [ID_W:0]   lk0_id,
    output logic            lk0_busy,
    input  logic [ID_W:0]   lk1_id,
    output logic            lk1_busy,
    output logic [ID_W+1:0] count
);
    localparam int NID = 2 ** (ID_W + 1);
    localparam logic [ID_W+1:0] CNT_ONE = {{(ID_W+1){1'b0}}, 1'b1};

    logic [NID-1:0]  busy_r;
    logic [NID-1:0]  busy_nxt_s;
    logic [ID_W+1:0] count_r;
    logic            inc_s;
    logic            dec_s;

    assign lk0_busy = busy_r[lk0_id];
    assign lk1_busy = busy_r[lk1_id];
    assign count    = count_r;

    // A same-cycle set wins over a clear of the same ID.
    assign inc_s = set_en & ~busy_r[set_id];
    assign dec_s = clr_en & busy_r[clr_id] & ~(set_en & (set_id == clr_id));

    // Next busy vector: clear first, then set so the set dominates.
    always_comb begin
        busy_nxt_s = busy_r;
        if (clr_en) begin
            busy_nxt_s[clr_id] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_en) begin
            busy_nxt_s[set_id] = 1'b1;
        end else begin
            busy_nxt_s[set_id] = busy_nxt_s[set_id];
        end
    end

    // Busy bits and the popcount tracked incrementally.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= {NID{1'b0}};
            count_r <= {(ID_W+2){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            case ({inc_s, dec_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/enigma_arb.sv
// Two-port QoS/round-robin arbiter with one-entry output stage and ID scoreboard.
// Optional starvation aging is enabled by defining ENIGMA_ARB_AGING_EN.
module enigma_arb
    import enigma_pkg::*;
#(
    parameter int PLD_W      = DEF_PLD_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int QOS_W      = DEF_QOS_W,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic            clk,
    input  logic            rst,
    enigma_arb_if.slave     a,
    enigma_arb_if.slave     b,
    enigma_arb_if.master    c,
    input  logic            conflict_c,
    input  logic            release_c,
    input  logic [ID_W:0]   releaseid_c,
    output logic [ID_W+1:0] outstanding
);
    out_state_e       state_r;
    logic [PLD_W-1:0] payload_r;
    logic [ID_W:0]    id_r;
    logic [QOS_W-1:0] qos_r;
    logic             prio_b_r;

    logic busy_a_s, busy_b_s, elig_a_s, elig_b_s;
    logic consumed_s, load_s, pick_a_s, grant_a_s, grant_b_s;
    logic sat_a_s, sat_b_s;
    logic [ID_W:0] set_id_s;

    assign consumed_s = (state_r == FULL) & c.ready & ~conflict_c;
    assign load_s     = (state_r == EMPTY) | consumed_s;
    assign elig_a_s   = a.valid & ~busy_a_s;
    assign elig_b_s   = b.valid & ~busy_b_s;
    assign set_id_s   = grant_b_s ? {PORT_B, b.id} : {PORT_A, a.id};

    enigma_id_sb #(.ID_W(ID_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (grant_a_s | grant_b_s),
        .set_id   (set_id_s),
        .clr_en   (release_c),
        .clr_id   (releaseid_c),
        .lk0_id   ({PORT_A, a.id}),
        .lk0_busy (busy_a_s),
        .lk1_id   ({PORT_B, b.id}),
        .lk1_busy (busy_b_s),
        .count    (outstanding)
    );

    // Grant decision: saturated aging first, then qos, then round-robin.
    always_comb begin
        pick_a_s  = 1'b1;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (sat_a_s != sat_b_s) begin
            pick_a_s = sat_a_s;
        end else if (sat_a_s) begin
            pick_a_s = ~prio_b_r;
        end else if (a.qos > b.qos) begin
            pick_a_s = 1'b1;
        end else if (b.qos > a.qos) begin
            pick_a_s = 1'b0;
        end else begin
            pick_a_s = ~prio_b_r;
        end
        if (load_s & ~rst) begin
            if (elig_a_s & elig_b_s) begin
                grant_a_s = pick_a_s;
                grant_b_s = ~pick_a_s;
            end else begin
                grant_a_s = elig_a_s;
                grant_b_s = elig_b_s;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a.ready   = grant_a_s;
    assign b.ready   = grant_b_s;
    assign c.valid   = (state_r == FULL);
    assign c.payload = payload_r;
    assign c.id      = id_r;
    assign c.qos     = qos_r;

    // Output stage: a grant always loads, otherwise a consumed beat empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= EMPTY;
            payload_r <= {PLD_W{1'b0}};
            id_r      <= {(ID_W+1){1'b0}};
            qos_r     <= {QOS_W{1'b0}};
        end else if (grant_a_s) begin
            state_r   <= FULL;
            payload_r <= a.payload;
            id_r      <= {PORT_A, a.id};
            qos_r     <= a.qos;
        end else if (grant_b_s) begin
            state_r   <= FULL;
            payload_r <= b.payload;
            id_r      <= {PORT_B, b.id};
            qos_r     <= b.qos;
        end else if (consumed_s) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_r;
        end
    end

    // Round-robin pointer: favour the port not granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_r <= 1'b0;
        end else if (grant_a_s) begin
            prio_b_r <= 1'b1;
        end else if (grant_b_s) begin
            prio_b_r <= 1'b0;
        end else begin
            prio_b_r <= prio_b_r;
        end
    end

`ifdef ENIGMA_ARB_AGING_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
    localparam logic [SW-1:0] ONE = SW'(1);

    logic [SW-1:0] starve_a_r;
    logic [SW-1:0] starve_b_r;

    assign sat_a_s = (starve_a_r == LIM);
    assign sat_b_s = (starve_b_r == LIM);

    // Saturating wait counters, counted only while a grant was possible.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_a_r <= {SW{1'b0}};
            starve_b_r <= {SW{1'b0}};
        end else begin
            if (grant_a_s) begin
                starve_a_r <= {SW{1'b0}};
            end else if (elig_a_s & load_s & ~sat_a_s) begin
                starve_a_r <= starve_a_r + ONE;
            end else begin
                starve_a_r <= starve_a_r;
            end
            if (grant_b_s) begin
                starve_b_r <= {SW{1'b0}};
            end else if (elig_b_s & load_s & ~sat_b_s) begin
                starve_b_r <= starve_b_r + ONE;
            end else begin
                starve_b_r <= starve_b_r;
            end
        end
    end
`else
    assign sat_a_s = 1'b0;
    assign sat_b_s = 1'b0;
`endif

endmodule

// File: tb/tb_enigma_arb.sv
// Directed self-checking bench for enigma_arb (aging step only with ENIGMA_ARB_AGING_EN).
module tb_enigma_arb;
    localparam int PLD_W = 128;
    localparam int ID_W  = 5;
    localparam int QOS_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             conflict_c;
    logic             release_c;
    logic [ID_W:0]    releaseid_c;
    logic [ID_W+1:0]  outstanding;
    int               checks = 0;
    int               errors = 0;
    logic [ID_W-1:0]  ida, idb;
    logic [ID_W:0]    exp_id;
    int               a_cycle;

    enigma_arb_if #(.PLD_W(PLD_W), .ID_W(ID_W),   .QOS_W(QOS_W)) a_if ();
    enigma_arb_if #(.PLD_W(PLD_W), .ID_W(ID_W),   .QOS_W(QOS_W)) b_if ();
    enigma_arb_if #(.PLD_W(PLD_W), .ID_W(ID_W+1), .QOS_W(QOS_W)) c_if ();

    enigma_arb #(.PLD_W(PLD_W), .ID_W(ID_W), .QOS_W(QOS_W), .STARVE_LIM(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if),
        .b           (b_if),
        .c           (c_if),
        .conflict_c  (conflict_c),
        .release_c   (release_c),
        .releaseid_c (releaseid_c),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PLD_W-1:0] obs, input logic [PLD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = '0;
        a_if.payload = '0; a_if.id = '0; a_if.qos = '0; a_if.valid = 1'b1;
        b_if.payload = '0; b_if.id = '0; b_if.qos = '0; b_if.valid = 1'b0;
        c_if.ready = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_ready_a", a_if.ready, 1'b0);
        chk("rst_valid_c", c_if.valid, 1'b0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_id_c", c_if.id, 0);
        chk("rst_payload_c", c_if.payload, 0);
        a_if.valid = 1'b0;
        rst = 1'b0;

        // Higher qos on B wins, then A follows.
        a_if.payload = 128'hA1; a_if.id = 5'd3; a_if.qos = 2'd1; a_if.valid = 1'b1;
        b_if.payload = 128'hB1; b_if.id = 5'd3; b_if.qos = 2'd2; b_if.valid = 1'b1;
        c_if.ready = 1'b1;
        #1;
        chk("qos_ready_b", b_if.ready, 1'b1);
        chk("qos_ready_a", a_if.ready, 1'b0);
        @(negedge clk);
        chk("qos_valid_c", c_if.valid, 1'b1);
        chk("qos_id_c_b", c_if.id, 6'h23);
        chk("qos_payload_b", c_if.payload, 128'hB1);
        chk("qos_qos_c", c_if.qos, 2'd2);
        chk("qos_outstanding1", outstanding, 1);
        b_if.valid = 1'b0;
        #1;
        chk("qos_ready_a2", a_if.ready, 1'b1);
        @(negedge clk);
        chk("qos_id_c_a", c_if.id, 6'h03);
        chk("qos_payload_a", c_if.payload, 128'hA1);
        chk("qos_outstanding2", outstanding, 2);
        a_if.valid = 1'b0;
        release_c = 1'b1; releaseid_c = 6'h23;
        @(negedge clk);
        chk("rel_outstanding1", outstanding, 1);
        chk("rel_valid_c", c_if.valid, 1'b0);
        releaseid_c = 6'h03;
        @(negedge clk);
        chk("rel_outstanding0", outstanding, 0);
        release_c = 1'b0;

        // Equal qos streaming alternates A, B, A, B from reset.
        do_reset();
        ida = 5'd10; idb = 5'd10;
        a_if.qos = 2'd0; b_if.qos = 2'd0; a_if.valid = 1'b1; b_if.valid = 1'b1;
        c_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.id = ida; b_if.id = idb;
            #1;
            chk("rr_ready_a", a_if.ready, (i % 2) == 0);
            chk("rr_ready_b", b_if.ready, (i % 2) == 1);
            exp_id = ((i % 2) == 0) ? {1'b0, ida} : {1'b1, idb};
            @(negedge clk);
            chk("rr_valid_c", c_if.valid, 1'b1);
            chk("rr_id_c", c_if.id, exp_id);
            if ((i % 2) == 0) ida = ida + 5'd1;
            else              idb = idb + 5'd1;
        end
        chk("rr_outstanding", outstanding, 4);
        a_if.valid = 1'b0; b_if.valid = 1'b0;

        // Busy ID blocks until released.
        do_reset();
        a_if.id = 5'd7; a_if.qos = 2'd0; a_if.payload = 128'h35; a_if.valid = 1'b1;
        #1;
        chk("busy_ready_first", a_if.ready, 1'b1);
        @(negedge clk);
        chk("busy_outstanding1", outstanding, 1);
        chk("busy_id_c", c_if.id, 6'h07);
        #1;
        chk("busy_blocked", a_if.ready, 1'b0);
        @(negedge clk);
        chk("busy_outstanding_hold", outstanding, 1);
        chk("busy_valid_c0", c_if.valid, 1'b0);
        release_c = 1'b1; releaseid_c = 6'h07;
        #1;
        chk("busy_blocked_rel", a_if.ready, 1'b0);
        @(negedge clk);
        chk("busy_outstanding0", outstanding, 0);
        release_c = 1'b0;
        #1;
        chk("busy_regrant", a_if.ready, 1'b1);
        @(negedge clk);
        chk("busy_outstanding1b", outstanding, 1);
        chk("busy_id_c2", c_if.id, 6'h07);
        a_if.valid = 1'b0; a_if.payload = 128'h99;

        // Conflict holds the beat for three extra cycles.
        conflict_c = 1'b1;
        b_if.id = 5'd1; b_if.qos = 2'd0; b_if.payload = 128'hB6; b_if.valid = 1'b1;
        #1;
        chk("cfl_ready_b", b_if.ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cfl_valid_c", c_if.valid, 1'b1);
            chk("cfl_payload", c_if.payload, 128'h35);
            chk("cfl_id_c", c_if.id, 6'h07);
            chk("cfl_outstanding", outstanding, 1);
            if (k < 2) begin
                #1;
                chk("cfl_ready_b", b_if.ready, 1'b0);
            end
        end
        conflict_c = 1'b0;
        #1;
        chk("cfl_consume_ready_b", b_if.ready, 1'b1);
        @(negedge clk);
        chk("cfl_next_id", c_if.id, 6'h21);
        chk("cfl_next_payload", c_if.payload, 128'hB6);
        chk("cfl_outstanding2", outstanding, 2);
        b_if.valid = 1'b0; c_if.ready = 1'b0;

        // Reset while FULL with five outstanding IDs.
        c_if.ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            a_if.id = 5'(k); a_if.payload = 128'(k); a_if.valid = 1'b1;
            @(negedge clk);
        end
        a_if.valid = 1'b0; c_if.ready = 1'b0;
        chk("mid_outstanding5", outstanding, 5);
        chk("mid_valid_c", c_if.valid, 1'b1);
        chk("mid_id_c", c_if.id, 6'h03);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid_c", c_if.valid, 1'b0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_payload", c_if.payload, 0);
        a_if.id = 5'd7; a_if.qos = 2'd0; a_if.valid = 1'b1;
        b_if.id = 5'd1; b_if.qos = 2'd0; b_if.valid = 1'b1;
        #1;
        chk("mid_elig_ready_a", a_if.ready, 1'b1);
        chk("mid_elig_ready_b", b_if.ready, 1'b0);
        @(negedge clk);
        chk("mid_post_id_c", c_if.id, 6'h07);
        chk("mid_post_outstanding", outstanding, 1);
        a_if.valid = 1'b0; b_if.valid = 1'b0;

`ifdef ENIGMA_ARB_AGING_EN
        // Low-qos A must win once its wait counter saturates.
        do_reset();
        idb = 5'd0; a_cycle = 0;
        a_if.id = 5'd20; a_if.qos = 2'd0; a_if.valid = 1'b1;
        b_if.qos = 2'd3; b_if.valid = 1'b1;
        c_if.ready = 1'b1;
        for (int n = 1; n <= 12 && a_cycle == 0; n++) begin
            b_if.id = idb;
            #1;
            if (a_if.ready) a_cycle = n;
            else if (b_if.ready) idb = idb + 5'd1;
            @(negedge clk);
        end
        chk("aging_a_cycle", a_cycle, 9);
        a_if.valid = 1'b0; b_if.valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enigma_arb.md
ENIGMA_ARB -- requirements
Module: enigma_arb

Interface
REQ-001 SHALL have parameter PLD_W, default 128, payload width of ports A, B and C.
REQ-002 SHALL have parameter ID_W, default 5, ID width of ports A and B; port C ID width is ID_W+1.
REQ-003 SHALL have parameter QOS_W, default 2, QoS width; a larger value means higher priority.
REQ-004 SHALL have parameter STARVE_LIM, default 8, the aging threshold in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports payload_a/id_a/qos_a/valid_a, inputs, PLD_W/ID_W/QOS_W/1 bits: request port A.
REQ-008 SHALL have port ready_a, output, 1 bit: port A accept.
REQ-009 SHALL have ports payload_b/id_b/qos_b/valid_b, inputs, PLD_W/ID_W/QOS_W/1 bits: request port B.
REQ-010 SHALL have port ready_b, output, 1 bit: port B accept.
REQ-011 SHALL have ports payload_c/id_c/qos_c/valid_c, outputs, PLD_W/ID_W+1/QOS_W/1 bits: merged output.
REQ-012 SHALL have port ready_c, input, 1 bit: downstream accept.
REQ-013 SHALL have port conflict_c, input, 1 bit: downstream rejects the current beat; the beat is retried.
REQ-014 SHALL have ports release_c/releaseid_c, inputs, 1/ID_W+1 bits: downstream retires an outstanding ID.
REQ-015 SHALL have port outstanding, output, ID_W+2 bits: count of busy IDs.

Function
REQ-016 SHALL hold a one-entry output register, state EMPTY or FULL; valid_c = FULL.
REQ-017 SHALL treat the beat as consumed in a cycle with valid_c & ready_c & ~conflict_c. With conflict_c=1 the beat SHALL stay unchanged and be presented again next cycle.
REQ-018 SHALL set load = EMPTY | consumed; it SHALL grant at most one port per cycle, and only when load=1.
REQ-019 SHALL make port X eligible when valid_X=1 and busy[{X, id_X}]=0, with A encoded as 0 and B as 1 in the ID MSB.
REQ-020 SHALL grant the eligible port with the higher qos; on an equal-qos tie it SHALL grant the port not granted last (round-robin pointer, A after reset).
REQ-021 SHALL drive ready_X = load & grant_X combinationally in the grant cycle; the payload, {X, id_X} and qos_X SHALL be registered into the output stage (1-cycle latency, valid_c at the next edge).
REQ-022 SHALL set busy[{X, id_X}] at the grant edge and clear busy[releaseid_c] when release_c=1. A set and a clear of the same ID in the same cycle SHALL leave the ID busy.
REQ-023 SHALL ignore release_c for an ID that is not busy, with no count change.
REQ-024 SHALL make outstanding equal the popcount of busy, kept as an incremental counter that never wraps (maximum 2^(ID_W+1)).
REQ-025 SHALL keep the output FULL with no grant while consumed=0; on the FULL->FULL path (consume plus grant in the same cycle) throughput SHALL be 1 beat per cycle.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear: output register EMPTY; valid_c/payload_c/id_c/qos_c = 0; ready_a = ready_b = 0; busy = 0; outstanding = 0; round-robin pointer = A; starvation counters = 0.
REQ-027 SHALL discard a FULL beat when reset is asserted mid-operation, with no replay after reset.

Configuration
REQ-028 SHALL, with macro ENIGMA_ARB_AGING_EN defined, keep a per-port saturating counter (width clog2(STARVE_LIM+1)): +1 each cycle the port is eligible and load=1 but not granted, cleared on that port's grant.
REQ-029 SHALL, under aging, force-grant a port whose counter equals STARVE_LIM over qos; if both ports are saturated, round-robin SHALL decide.
REQ-030 SHALL, without ENIGMA_ARB_AGING_EN, use pure qos plus round-robin arbitration and instantiate no counters.

Structure
REQ-031 SHALL place in package enigma_pkg: the PORT_A=0 and PORT_B=1 constants, the out_state_e {EMPTY, FULL} typedef, and the default widths.
REQ-032 SHALL implement the busy scoreboard (set, clear, lookup x2, count) as sub-module enigma_id_sb; the arbiter and output stage SHALL live in enigma_arb.

Verification
REQ-033 SHALL cover: A qos=1 id=3 and B qos=2 id=3 valid together with ready_c=1 -> B granted, id_c=6'h23 next cycle, then A granted, id_c=6'h03.
REQ-034 SHALL cover: both ports qos=0 streaming continuously with ready_c=1 -> grants alternate A, B, A, B starting at A, one beat per cycle.
REQ-035 SHALL cover: A id=7 sent, no release, A id=7 again -> second beat blocked (ready_a=0). Then release_c=1, releaseid_c=6'h07 -> granted the next cycle; outstanding goes 1,0,1.
REQ-036 SHALL cover: valid_c=1, conflict_c=1 for 3 cycles then 0 -> identical beat held for 4 cycles, consumed once, outstanding unchanged.
REQ-037 SHALL cover: rst pulsed while FULL with outstanding=5 -> next cycle valid_c=0, outstanding=0, all IDs eligible.
REQ-038 SHALL cover, with ENIGMA_ARB_AGING_EN: B qos=3 continuous, A qos=0 continuous, distinct IDs released promptly -> A granted no later than its STARVE_LIM+1 = 9th load cycle.
